// File: rtl/quant_pkg.sv
// Shared constants and FSM state type for the requantisation / ReLU stage.
package quant_pkg;

    localparam int N_LANES   = 16;
    localparam int C1_LANES  = 6;
    localparam int C1_PIXELS = 784;
    localparam int C2_PIXELS = 100;

    localparam logic signed [7:0] INT8_MAX = 8'h7F;
    localparam logic signed [7:0] INT8_MIN = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/quant_lane.sv
// One lane of the requantisation pipe: multiply, round/shift, then ReLU, zero point and int8 clamp.
module quant_lane
    import quant_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic signed [31:0] x,
    input  logic [15:0]       mult,
    input  logic [4:0]        shift,
    input  logic signed [7:0] zp,
    input  logic              relu_en,
    input  logic              lane_active,
    output logic signed [7:0] y,
    output logic              sat
);

    localparam logic signed [48:0] SAT_HI = 49'(INT8_MAX);
    localparam logic signed [48:0] SAT_LO = 49'(INT8_MIN);

    logic signed [48:0] x_ext;
    logic signed [48:0] m_ext;
    logic signed [48:0] prod_q;
    logic signed [48:0] rnd;
    logic signed [48:0] shifted_q;
    logic signed [48:0] relu_v;
    logic signed [48:0] biased;
    logic signed [7:0]  y_d;
    logic               sat_d;

    // The multiplier is treated as unsigned, so it is zero-extended before the signed product.
    assign x_ext = 49'(x);
    assign m_ext = {33'd0, mult};

    always_comb begin
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = 49'sd1 <<< (shift - 5'd1);
        end
    end

    always_comb begin
        relu_v = shifted_q;
        if (relu_en && shifted_q[48]) begin
            relu_v = '0;
        end
        biased = relu_v + 49'(zp);
        y_d    = biased[7:0];
        sat_d  = 1'b0;
        if (biased > SAT_HI) begin
            y_d   = INT8_MAX;
            sat_d = 1'b1;
        end else if (biased < SAT_LO) begin
            y_d   = INT8_MIN;
            sat_d = 1'b1;
        end
        if (!lane_active) begin
            y_d   = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q    <= '0;
            shifted_q <= '0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            prod_q    <= x_ext * m_ext;
            shifted_q <= (prod_q + rnd) >>> shift;
            y         <= y_d;
            sat       <= sat_d;
        end
    end

endmodule

// File: rtl/quant_relu_stage.sv
// Frame-level requantisation stage: FSM, pixel counter, config latches and the per-lane pipes.
module quant_relu_stage
    import quant_pkg::*;
#(
    parameter int N_LANES = 16,
    parameter int ADDR_W  = 10
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stateC1_in,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [32*N_LANES-1:0]  in_data,
    input  logic [15:0]            mult,
    input  logic [4:0]             shift,
    input  logic [7:0]             zero_point,
    input  logic                   relu_en,
    output logic                   out_valid,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [8*N_LANES-1:0]   out_data,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag
);

    state_t state;
    state_t state_next;

    logic              c1_q;
    logic [15:0]       mult_q;
    logic [4:0]        shift_q;
    logic [7:0]        zp_q;
    logic              relu_q;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] idx1, idx2, idx3;
    logic [2:0]        vld;
    logic              accept;
    logic              last_beat;
    logic              start_ok;
    logic [N_LANES-1:0] lane_sat;

    assign start_ok  = (state == IDLE) && start;
    assign accept    = (state == RUN) && in_valid;
    assign last_idx  = c1_q ? ADDR_W'(C1_PIXELS - 1) : ADDR_W'(C2_PIXELS - 1);
    assign last_beat = accept && (cnt == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN ends when the final beat sits alone in the output register.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (last_beat) state_next = DRAIN;
            DRAIN: if (vld[2] && (vld[1:0] == 2'b00)) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q    <= 1'b0;
            mult_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            relu_q  <= 1'b0;
            cnt     <= '0;
        end else if (start_ok) begin
            c1_q    <= stateC1_in;
            mult_q  <= mult;
            shift_q <= shift;
            zp_q    <= zero_point;
            relu_q  <= relu_en;
            cnt     <= '0;
        end else if (accept) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Valid bits and pixel indices travel alongside the three arithmetic stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            idx1 <= '0;
            idx2 <= '0;
            idx3 <= '0;
        end else begin
            vld  <= {vld[1:0], accept};
            idx1 <= cnt;
            idx2 <= idx1;
            idx3 <= idx2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (start_ok) begin
            sat_flag <= 1'b0;
        end else if (vld[2] && (|lane_sat)) begin
            sat_flag <= 1'b1;
        end
    end

    assign out_valid = vld[2];
    assign out_addr  = idx3;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic active;
        assign active = c1_q ? (i < C1_LANES) : 1'b1;

        quant_lane u_lane (
            .clk         (clk),
            .rst         (rst),
            .x           (in_data[32*i +: 32]),
            .mult        (mult_q),
            .shift       (shift_q),
            .zp          (zp_q),
            .relu_en     (relu_q),
            .lane_active (active),
            .y           (out_data[8*i +: 8]),
            .sat         (lane_sat[i])
        );
    end

endmodule

// File: tb/tb_quant_relu_stage.sv
// Randomised frame-level bench for quant_relu_stage against an arithmetic reference model.
module tb_quant_relu_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         stateC1_in;
    logic         start;
    logic         in_valid;
    logic [511:0] in_data;
    logic [15:0]  mult;
    logic [4:0]   shift;
    logic [7:0]   zero_point;
    logic         relu_en;
    logic         out_valid;
    logic [9:0]   out_addr;
    logic [127:0] out_data;
    logic         busy;
    logic         done;
    logic         sat_flag;

    typedef struct packed {
        logic [9:0]   addr;
        logic [127:0] data;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;
    int     last_cyc = 0;
    int     done_count = 0;
    bit     cfg_c1;
    int     cfg_mult, cfg_shift, cfg_zp;
    bit     cfg_relu;
    bit     model_sat;
    int     next_idx;
    logic [127:0] cap0;
    bit     want_first = 0;
    logic [9:0] first_addr = '1;

    quant_relu_stage #(.N_LANES(16), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .stateC1_in (stateC1_in),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .mult       (mult),
        .shift      (shift),
        .zero_point (zero_point),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Requantise one value with wide integer arithmetic.
    function automatic void model_lane(input logic signed [31:0] x, input int m, input int sh,
                                       input int zp, input bit relu,
                                       output logic [7:0] y, output bit s);
        longint v;
        v = longint'(x) * longint'(m);
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        v = v + longint'(zp);
        s = 1'b0;
        if (v > 127) begin v = 127; s = 1'b1; end
        else if (v < -128) begin v = -128; s = 1'b1; end
        y = v[7:0];
    endfunction

    function automatic logic [127:0] model_beat(input logic [511:0] d, output bit s);
        logic [127:0] r;
        logic [7:0]   y;
        bit           ls;
        int           active;
        r = '0;
        s = 1'b0;
        active = cfg_c1 ? 6 : 16;
        for (int i = 0; i < active; i++) begin
            model_lane(d[32*i +: 32], cfg_mult, cfg_shift, cfg_zp, cfg_relu, y, ls);
            r[8*i +: 8] = y;
            s = s | ls;
        end
        return r;
    endfunction

    function automatic logic [511:0] make_beat(input int mode, input int idx);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        case (mode)
            0: begin d[31:0] = 32'(idx); d[32*7 +: 32] = 32'd5; end
            1: begin d[31:0] = 32'd5; d[63:32] = 32'hFFFF_FFFB; end
            2: begin d[31:0] = 32'h7FFF_FFFF; d[63:32] = 32'h8000_0000; end
            default: for (int i = 0; i < 16; i++)
                d[32*i +: 32] = $urandom_range(0, 32'h1F_FFFF) - 32'h10_0000;
        endcase
        return d;
    endfunction

    // Compare every output beat against the model queue, in order.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (want_first) begin
                first_addr = out_addr;
                want_first = 0;
            end
            if (out_addr == 10'd0) cap0 = out_data;
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_beat: got addr %0d, required no output", out_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("beat", {22'd0, out_addr, out_data}, {22'd0, e.addr, e.data});
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_count++;

    task automatic applyStimulus(input bit valid, input logic [511:0] d, input bit accepted);
        logic [127:0] y;
        bit           s;
        exp_t         e;
        in_valid = valid;
        in_data  = d;
        if (valid && accepted) begin
            y = model_beat(d, s);
            model_sat = model_sat | s;
            e.addr = 10'(next_idx);
            e.data = y;
            exp_q.push_back(e);
            next_idx++;
            last_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int k;
        int dc;
        dc = done_count;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_seen", 160'(done), 160'd1);
        checkOutput("done_latency", 160'(cyc - last_cyc), 160'd4);
        @(negedge clk);
        checkOutput("busy_fall", {158'd0, busy, done}, 160'd0);
        repeat (3) @(negedge clk);
        checkOutput("done_once", 160'(done_count - dc), 160'd1);
        checkOutput("all_beats_out", 160'(exp_q.size()), 160'd0);
        checkOutput("sat_flag", 160'(sat_flag), 160'(model_sat));
    endtask

    task automatic run_frame(input bit c1, input int m, input int sh, input int zp, input bit relu,
                             input int mode, input bit gaps, input int abort_at, input bit mult_change);
        int n;
        int dc;
        stateC1_in = c1;
        mult       = 16'(m);
        shift      = 5'(sh);
        zero_point = 8'(zp);
        relu_en    = relu;
        start      = 1'b1;
        in_valid   = 1'b1;
        in_data    = make_beat(mode, 0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        cfg_c1    = c1;
        cfg_mult  = m & 16'hFFFF;
        cfg_shift = sh;
        cfg_zp    = zp;
        cfg_relu  = relu;
        model_sat = 1'b0;
        next_idx  = 0;
        checkOutput("start_clears_sat", 160'(sat_flag), 160'd0);
        checkOutput("busy_run", 160'(busy), 160'd1);
        n = c1 ? 784 : 100;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                if (i == 10) begin
                    start      = 1'b1;
                    mult       = 16'(m + 5);
                    stateC1_in = !c1;
                end
                applyStimulus(1'b0, make_beat(mode, i), 1'b0);
                start      = 1'b0;
                mult       = 16'(m);
                stateC1_in = c1;
            end
            applyStimulus(1'b1, make_beat(mode, i), 1'b1);
            if (mult_change && i == 20) mult = 16'(m + 1);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                checkOutput("reset_outputs", {18'd0, out_valid, out_addr, out_data, busy, done, sat_flag}, 160'd0);
                exp_q.delete();
                dc = done_count;
                repeat (3) @(posedge clk);
                #1;
                rst      = 1'b0;
                in_valid = 1'b0;
                repeat (8) @(negedge clk);
                checkOutput("no_done_after_abort", 160'(done_count - dc), 160'd0);
                return;
            end
        end
        applyStimulus(1'b1, make_beat(mode, 0), 1'b0);
        in_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] y;
        bit         s;
        rst = 1'b1;
        stateC1_in = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        mult = '0; shift = '0; zero_point = '0; relu_en = 1'b0;
        #2;
        checkOutput("reset_state", {18'd0, out_valid, out_addr, out_data, busy, done, sat_flag}, 160'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the reference model to hand-derived values.
        model_lane(32'd5, 1, 1, 0, 0, y, s);           checkOutput("model_round_pos", 160'(y), 160'h03);
        model_lane(32'hFFFF_FFFB, 1, 1, 0, 0, y, s);   checkOutput("model_round_neg", 160'(y), 160'hFE);
        model_lane(32'hFFFF_FFFB, 1, 1, 0, 1, y, s);   checkOutput("model_relu", 160'(y), 160'h00);
        model_lane(32'hFFFF_FFFB, 1, 1, -10, 1, y, s); checkOutput("model_zp", 160'(y), 160'hF6);
        model_lane(32'h7FFF_FFFF, 65535, 0, 0, 0, y, s); checkOutput("model_sat_hi", {151'd0, s, y}, {151'd0, 1'b1, 8'h7F});
        model_lane(32'h8000_0000, 65535, 0, 0, 0, y, s); checkOutput("model_sat_lo", {151'd0, s, y}, {151'd0, 1'b1, 8'h80});

        $display("[TB] C1 frame");
        run_frame(1'b1, 1, 0, 0, 1'b0, 0, 1'b0, -1, 1'b0);
        checkOutput("c1_lane0_addr0", 160'(cap0[7:0]), 160'd0);
        checkOutput("c1_lane7_off", 160'(cap0[63:56]), 160'd0);
        checkOutput("c1_sat", 160'(sat_flag), 160'd1);

        $display("[TB] rounding and relu frames");
        run_frame(1'b0, 1, 1, 0, 1'b0, 1, 1'b0, -1, 1'b0);
        checkOutput("dut_round_pos", 160'(cap0[7:0]), 160'h03);
        checkOutput("dut_round_neg", 160'(cap0[15:8]), 160'hFE);
        run_frame(1'b0, 1, 1, 0, 1'b1, 1, 1'b0, -1, 1'b0);
        checkOutput("dut_relu", 160'(cap0[15:8]), 160'h00);
        run_frame(1'b0, 1, 1, -10, 1'b1, 1, 1'b0, -1, 1'b0);
        checkOutput("dut_zp_neg", 160'(cap0[15:8]), 160'hF6);
        checkOutput("dut_zp_pos", 160'(cap0[7:0]), 160'hF9);

        $display("[TB] saturation frame");
        run_frame(1'b0, 65535, 0, 0, 1'b0, 2, 1'b0, -1, 1'b0);
        checkOutput("dut_sat_hi", 160'(cap0[7:0]), 160'h7F);
        checkOutput("dut_sat_lo", 160'(cap0[15:8]), 160'h80);
        repeat (5) @(negedge clk);
        checkOutput("sat_sticky", 160'(sat_flag), 160'd1);

        $display("[TB] C2 frame with gaps");
        run_frame(1'b0, int'($urandom_range(1, 65535)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 255)) - 128, 1'($urandom), 3, 1'b1, -1, 1'b0);

        $display("[TB] config latch");
        run_frame(1'b0, 2, 2, 0, 1'b0, 3, 1'b0, -1, 1'b1);

        $display("[TB] reset mid-run");
        run_frame(1'b0, 3, 4, 5, 1'b0, 3, 1'b0, 50, 1'b0);
        want_first = 1;
        run_frame(1'b0, int'($urandom_range(1, 65535)), int'($urandom_range(8, 31)),
                  int'($urandom_range(0, 255)) - 128, 1'($urandom), 3, 1'b0, -1, 1'b0);
        checkOutput("first_addr_after_reset", 160'(first_addr), 160'd0);

        $display("[TB] random C1 frame");
        run_frame(1'b1, int'($urandom_range(1, 65535)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 255)) - 128, 1'($urandom), 3, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
